// File: rtl/mlp_sequencer_if.sv
// Handshake bundle between the classifier sequencer and its two dense layers.
//   master : the sequencer (drives layer resets/enables and the result outputs)
//   slave  : the environment (drives start, layer done flags and layer-2 scores)
// Signals:
//   start                 begin one inference
//   l1_reset, l1_enable   layer-1 control        l1_done  layer-1 finished
//   l2_reset, l2_enable   layer-2 control        l2_done  layer-2 finished
//   l2_out                N_CLASSES packed signed DATA_W scores, element i = class i
//   busy, digit, digit_valid, error   sequencer status / result
interface mlp_sequencer_if #(
    parameter int unsigned N_CLASSES = 10,
    parameter int unsigned DATA_W    = 16
);
    logic                                start;
    logic                                l1_reset;
    logic                                l1_enable;
    logic                                l1_done;
    logic                                l2_reset;
    logic                                l2_enable;
    logic                                l2_done;
    logic [N_CLASSES-1:0][DATA_W-1:0]    l2_out;
    logic                                busy;
    logic [3:0]                          digit;
    logic                                digit_valid;
    logic                                error;

    modport master (
        input  start, l1_done, l2_done, l2_out,
        output l1_reset, l1_enable, l2_reset, l2_enable,
               busy, digit, digit_valid, error
    );

    modport slave (
        output start, l1_done, l2_done, l2_out,
        input  l1_reset, l1_enable, l2_reset, l2_enable,
               busy, digit, digit_valid, error
    );
endinterface

// File: rtl/mlp_sequencer.sv
// Top-level controller for the two-stage dense classifier: clears both layers,
// runs layer 1 then layer 2 under a per-layer watchdog, then scans the layer-2
// scores one per cycle and reports the argmax as the recognised digit.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    mlp_sequencer_if.master (layer control, scores, result/status)
// All outputs are registered; they are decoded from the next state so they
// line up with the state they describe.
module mlp_sequencer #(
    parameter int unsigned N_CLASSES = 10,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic            clk,
    input  logic            reset,
    mlp_sequencer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned IDX_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN1, S_RUN2, S_ARGMAX, S_DONE, S_ERR
    } state_t;

    state_t                     state, state_next;
    logic [CNT_W-1:0]           wd, wd_next;
    logic [IDX_W-1:0]           idx, idx_next;
    logic signed [DATA_W-1:0]   best_val, best_val_next, cur_val;
    logic [IDX_W-1:0]           best_idx, best_idx_next;
    logic [3:0]                 digit_q, digit_next;
    logic                       error_q, error_next;
    logic                       l1_reset_q, l1_reset_next;
    logic                       l2_reset_q, l2_reset_next;
    logic                       l1_enable_q, l1_enable_next;
    logic                       l2_enable_q, l2_enable_next;
    logic                       busy_q, busy_next;
    logic                       digit_valid_q, digit_valid_next;

    // Next-state, watchdog, argmax datapath and registered-output decode.
    always_comb begin
        state_next    = state;
        wd_next       = '0;
        idx_next      = '0;
        best_val_next = best_val;
        best_idx_next = best_idx;
        digit_next    = digit_q;
        error_next    = error_q;
        cur_val       = $signed(bus.l2_out[idx]);

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_CLR;
                    error_next = 1'b0;
                end
            end
            S_CLR: state_next = S_RUN1;
            S_RUN1: begin
                wd_next = wd + CNT_W'(1);
                // done is checked first so a coinciding timeout loses
                if (bus.l1_done) begin
                    state_next = S_RUN2;
                    wd_next    = '0;
                end else if (wd == WD_LAST) begin
                    state_next = S_ERR;
                    error_next = 1'b1;
                end
            end
            S_RUN2: begin
                wd_next = wd + CNT_W'(1);
                if (bus.l2_done) begin
                    state_next = S_ARGMAX;
                end else if (wd == WD_LAST) begin
                    state_next = S_ERR;
                    error_next = 1'b1;
                end
            end
            S_ARGMAX: begin
                idx_next = idx + IDX_W'(1);
                // strict compare keeps the lowest index on ties
                if ((idx == '0) || (cur_val > best_val)) begin
                    best_val_next = cur_val;
                    best_idx_next = idx;
                end
                if (idx == IDX_LAST) begin
                    state_next = S_DONE;
                    digit_next = 4'(best_idx_next);
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        l1_reset_next    = (state_next == S_CLR);
        l2_reset_next    = (state_next == S_CLR);
        l1_enable_next   = (state_next == S_RUN1) || (state_next == S_RUN2) ||
                           (state_next == S_ARGMAX);
        l2_enable_next   = (state_next == S_RUN2) || (state_next == S_ARGMAX);
        busy_next        = (state_next != S_IDLE);
        digit_valid_next = (state_next == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            wd            <= '0;
            idx           <= '0;
            best_val      <= '0;
            best_idx      <= '0;
            digit_q       <= '0;
            error_q       <= 1'b0;
            l1_reset_q    <= 1'b0;
            l2_reset_q    <= 1'b0;
            l1_enable_q   <= 1'b0;
            l2_enable_q   <= 1'b0;
            busy_q        <= 1'b0;
            digit_valid_q <= 1'b0;
        end else begin
            state         <= state_next;
            wd            <= wd_next;
            idx           <= idx_next;
            best_val      <= best_val_next;
            best_idx      <= best_idx_next;
            digit_q       <= digit_next;
            error_q       <= error_next;
            l1_reset_q    <= l1_reset_next;
            l2_reset_q    <= l2_reset_next;
            l1_enable_q   <= l1_enable_next;
            l2_enable_q   <= l2_enable_next;
            busy_q        <= busy_next;
            digit_valid_q <= digit_valid_next;
        end
    end

    assign bus.l1_reset    = l1_reset_q;
    assign bus.l2_reset    = l2_reset_q;
    assign bus.l1_enable   = l1_enable_q;
    assign bus.l2_enable   = l2_enable_q;
    assign bus.busy        = busy_q;
    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.error       = error_q;
endmodule

// File: tb/tb_mlp_sequencer.sv
// Self-checking bench for mlp_sequencer: directed and randomized inferences,
// every output compared each cycle against a timeline built from the
// sequencing rules and an argmax reference computed over an int array.
module tb_mlp_sequencer;
    localparam int unsigned N  = 10;
    localparam int unsigned W  = 16;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_digit = 0;
    int   exp_error = 0;
    int   scores [N];

    mlp_sequencer_if #(.N_CLASSES(N), .DATA_W(W)) bus ();

    mlp_sequencer #(.N_CLASSES(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare every output against the expected levels for this cycle.
    task automatic chk_outs(input string ph, input bit l1r, input bit l2r, input bit l1e,
                            input bit l2e, input bit bsy, input bit dv);
        chk({ph, ".l1_reset"},    32'(bus.l1_reset),    32'(l1r));
        chk({ph, ".l2_reset"},    32'(bus.l2_reset),    32'(l2r));
        chk({ph, ".l1_enable"},   32'(bus.l1_enable),   32'(l1e));
        chk({ph, ".l2_enable"},   32'(bus.l2_enable),   32'(l2e));
        chk({ph, ".busy"},        32'(bus.busy),        32'(bsy));
        chk({ph, ".digit_valid"}, 32'(bus.digit_valid), 32'(dv));
        chk({ph, ".digit"},       32'(bus.digit),       32'(exp_digit));
        chk({ph, ".error"},       32'(bus.error),       32'(exp_error));
    endtask

    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < N; i++)
            if (scores[i] > scores[best]) best = i;
        return best;
    endfunction

    task automatic apply_scores();
        for (int i = 0; i < N; i++) bus.l2_out[i] = W'(scores[i]);
    endtask

    task automatic err_path();
        exp_error = 1;
        chk_outs("err", 0, 0, 0, 0, 1, 0);
        tick();
        chk_outs("err_idle", 0, 0, 0, 0, 0, 0);
        tick();
        chk_outs("err_idle2", 0, 0, 0, 0, 0, 0);
    endtask

    // One inference; lat<=0 or lat>TO means done never arrives in time.
    task automatic run_inference(input int l1_lat, input int l2_lat,
                                 input bit extra_start, input int rst_at);
        bit ok;
        apply_scores();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_error = 0;
        chk_outs("clr", 1, 1, 0, 0, 1, 0);
        tick();

        ok = 0;
        for (int j = 0; j < TO; j++) begin
            chk_outs("run1", 0, 0, 1, 0, 1, 0);
            if (extra_start && j == 1) bus.start = 1'b1;
            if (j == l1_lat - 1) bus.l1_done = 1'b1;
            tick();
            bus.start   = 1'b0;
            bus.l1_done = 1'b0;
            if (j == l1_lat - 1) begin ok = 1; break; end
        end
        if (!ok) begin err_path(); return; end

        for (int j = 0; j < TO; j++) begin
            chk_outs("run2", 0, 0, 1, 1, 1, 0);
            if (j == rst_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                exp_error = 0;
                exp_digit = 0;
                chk_outs("mid_reset", 0, 0, 0, 0, 0, 0);
                tick();
                chk_outs("post_reset", 0, 0, 0, 0, 0, 0);
                return;
            end
            if (j == l2_lat - 1) bus.l2_done = 1'b1;
            tick();
            bus.l2_done = 1'b0;
            if (j == l2_lat - 1) begin ok = 0; break; end
        end
        if (ok) begin err_path(); return; end

        for (int i = 0; i < N; i++) begin
            chk_outs("argmax", 0, 0, 1, 1, 1, 0);
            if (extra_start && i == 3) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        exp_digit = ref_argmax();
        chk_outs("done", 0, 0, 0, 0, 1, 1);
        tick();
        chk_outs("idle", 0, 0, 0, 0, 0, 0);
        tick();
        chk_outs("idle2", 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic signed [W-1:0] r;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.l1_done = 1'b0;
        bus.l2_done = 1'b0;
        for (int i = 0; i < N; i++) scores[i] = 0;
        apply_scores();

        // Reset state
        tick();
        tick();
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_outs("idle_after_reset", 0, 0, 0, 0, 0, 0);

        // Nominal
        scores = '{0, -3, 12, 40, 5, 7, -100, 127, 30, 2};
        run_inference(14, 12, 0, -1);
        chk("nominal.digit7", 32'(bus.digit), 32'd7);

        // Ties and negatives
        scores = '{-9, -9, -9, 50, -9, -9, -9, -9, 50, -9};
        run_inference(3, 4, 0, -1);
        chk("tie.digit3", 32'(bus.digit), 32'd3);
        scores = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -2};
        run_inference(5, 2, 0, -1);
        chk("neg.digit9", 32'(bus.digit), 32'd9);

        // Layer-1 watchdog: digit keeps 9, next start clears error
        run_inference(0, 1, 0, -1);
        chk("wdog.error", 32'(bus.error), 32'd1);
        chk("wdog.digit_kept", 32'(bus.digit), 32'd9);
        scores = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_inference(2, 2, 0, -1);
        chk("zeros.digit0", 32'(bus.digit), 32'd0);

        // Layer-2 watchdog, then done/timeout coincidence in both layers
        scores = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        run_inference(4, 0, 0, -1);
        run_inference(3, TO, 0, -1);
        chk("coinc.error0", 32'(bus.error), 32'd0);
        run_inference(TO, 1, 0, -1);

        // Start pulses while busy are ignored
        scores = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        run_inference(6, 5, 1, -1);

        // Reset in RUN2, then a clean run
        run_inference(4, 10, 0, 5);
        scores = '{-1, 20, -300, 8, 20, 0, 19, -32768, 32767, 4};
        run_inference(7, 3, 0, -1);
        chk("post_reset.digit8", 32'(bus.digit), 32'd8);

        // Randomized inferences
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t % 2 == 0) r = W'($urandom);
                else            r = W'($urandom_range(0, 6)) - W'(3);
                scores[i] = int'(r);
            end
            run_inference(int'($urandom_range(1, TO)), int'($urandom_range(1, TO)),
                          bit'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
